// File: rtl/conbus_pkg.sv
// Shared definitions for the Wishbone interconnect scheduler: CTI codes, FSM states and
// the transfer-boundary test used to decide when ownership may rotate.
package conbus_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_OWNED, S_ABORT} state_e;

   // A completed beat that ends a transaction: classic cycle or last beat of a burst.
   function automatic logic is_boundary(input logic [2:0] cti);
      return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
   endfunction

endpackage

// File: rtl/conbus_sched_if.sv
// Arbiter-side view of the shared master bus: requests and handshake in, grant and status out.
interface conbus_sched_if #(
   parameter int unsigned N_MASTERS = 2
);
   localparam int unsigned IW = $clog2(N_MASTERS);

   logic [N_MASTERS-1:0] req;
   logic                 i_stb;
   logic [2:0]           i_cti;
   logic                 i_ack;
   logic [N_MASTERS-1:0] gnt;
   logic [IW-1:0]        gnt_idx;
   logic                 bus_err;
   logic                 busy;

   modport master (
      output req, i_stb, i_cti, i_ack,
      input  gnt, gnt_idx, bus_err, busy
   );

   modport slave (
      input  req, i_stb, i_cti, i_ack,
      output gnt, gnt_idx, bus_err, busy
   );
endinterface

// File: rtl/conbus_rr_pick.sv
// Combinational round-robin picker: first requester after last_idx, wrapping, so the
// previous winner is chosen only when it is the sole requester.
module conbus_rr_pick #(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last_idx,
   output logic [$clog2(N)-1:0] pick_idx,
   output logic                 pick_valid
);
   localparam int unsigned IW = $clog2(N);

   int unsigned   cand;
   logic [IW-1:0] cand_idx;

   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = last_idx;
      cand       = 0;
      cand_idx   = '0;
      for (int unsigned off = 1; off <= N; off++) begin
         cand     = (32'(last_idx) + off) % N;
         cand_idx = IW'(cand);
         if (!pick_valid && req[cand_idx]) begin
            pick_valid = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/conbus_sched.sv
// Registered round-robin arbiter with a per-owner transfer quantum and a bus watchdog that
// aborts a transfer with a one-cycle error pulse when no slave acknowledges.
module conbus_sched
   import conbus_pkg::*;
#(
   parameter int unsigned N_MASTERS = 2,
   parameter int unsigned MAX_HOLD  = 16,
   parameter int unsigned TIMEOUT   = 255
) (
   input logic           sys_clk,
   input logic           sys_rst,
   conbus_sched_if.slave bus
);
   localparam int unsigned IW     = $clog2(N_MASTERS);
   localparam logic [7:0]  QMax   = 8'(MAX_HOLD);
   localparam logic [15:0] WdLast = 16'(TIMEOUT - 1);

   state_e               state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [N_MASTERS-1:0] gnt_q, gnt_d;
   logic                 err_q, err_d;
   logic                 busy_q, busy_d;
   logic [7:0]           qcnt_q, qcnt_d, qnext;
   logic [15:0]          wdog_q, wdog_d;

   logic [IW-1:0]        pick_idx;
   logic                 pick_valid;
   logic [N_MASTERS-1:0] owner_mask;
   logic                 owner_req, others, complete, boundary;

   conbus_rr_pick #(
      .N (N_MASTERS)
   ) u_pick (
      .req        (bus.req),
      .last_idx   (idx_q),
      .pick_idx   (pick_idx),
      .pick_valid (pick_valid)
   );

   always_comb begin
      owner_mask        = '0;
      owner_mask[idx_q] = 1'b1;
      owner_req         = bus.req[idx_q];
      others            = |(bus.req & ~owner_mask);
      complete          = bus.i_stb & bus.i_ack;
      boundary          = complete & is_boundary(bus.i_cti);
      qnext             = qcnt_q;
      if (complete && (qcnt_q < QMax)) qnext = qcnt_q + 8'd1;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      qcnt_d  = qcnt_q;
      wdog_d  = wdog_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            qcnt_d = '0;
            wdog_d = '0;
            if (pick_valid) begin
               idx_d   = pick_idx;
               state_d = S_OWNED;
            end
         end
         S_OWNED: begin
            if (!owner_req) begin
               qcnt_d = '0;
               wdog_d = '0;
               if (others) idx_d = pick_idx;
               else        state_d = S_IDLE;
            end else if (boundary && (qnext >= QMax) && others) begin
               idx_d  = pick_idx;
               qcnt_d = '0;
               wdog_d = '0;
            end else begin
               qcnt_d = qnext;
               // An ack on the threshold cycle is a completion, not a timeout.
               if (bus.i_stb && !bus.i_ack) begin
                  if (wdog_q == WdLast) begin
                     state_d = S_ABORT;
                     err_d   = 1'b1;
                     wdog_d  = '0;
                  end else begin
                     wdog_d = wdog_q + 16'd1;
                  end
               end else begin
                  wdog_d = '0;
               end
            end
         end
         S_ABORT: begin
            wdog_d  = '0;
            state_d = owner_req ? S_OWNED : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      gnt_d        = '0;
      gnt_d[idx_d] = 1'b1;
      busy_d       = (state_d != S_IDLE);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         gnt_q   <= N_MASTERS'(1);
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         qcnt_q  <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gnt_q   <= gnt_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         qcnt_q  <= qcnt_d;
         wdog_q  <= wdog_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.gnt_idx = idx_q;
   assign bus.bus_err = err_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_conbus_sched.sv
// Bench for conbus_sched: directed vector table, hand-written corner sequences and a random
// run, all checked against a cycle-level reference of the arbitration rules.
module tb_conbus_sched;

   localparam int N  = 3;
   localparam int MH = 4;
   localparam int TO = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   conbus_sched_if #(.N_MASTERS(N)) bus ();

   conbus_sched #(
      .N_MASTERS (N),
      .MAX_HOLD  (MH),
      .TIMEOUT   (TO)
   ) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (bus)
   );

   // Reference state: 0 idle, 1 owned, 2 abort.
   int m_st = 0, m_own = 0, m_q = 0, m_wd = 0;
   bit m_err = 1'b0;
   int n_cmp = 0, n_bad = 0;

   function automatic int rr_pick(input int last, input logic [N-1:0] r);
      logic [N-1:0] sh;
      for (int off = 1; off <= N; off++) begin
         int c;
         c  = (last + off) % N;
         sh = r >> c;
         if (sh[0]) return c;
      end
      return -1;
   endfunction

   function automatic void model_step(input logic r_rst, input logic [N-1:0] r,
                                      input logic s, input logic [2:0] c, input logic a);
      logic [N-1:0] om;
      bit           others, own_req, done, bnd;
      int           p;
      if (r_rst) begin
         m_st = 0; m_own = 0; m_q = 0; m_wd = 0; m_err = 1'b0;
         return;
      end
      m_err   = 1'b0;
      om      = N'(1) << m_own;
      others  = (r & ~om) != '0;
      own_req = (r & om) != '0;
      p       = rr_pick(m_own, r);
      if (m_st == 0) begin
         m_q = 0; m_wd = 0;
         if (p >= 0) begin m_own = p; m_st = 1; end
      end else if (m_st == 1) begin
         if (!own_req) begin
            m_q = 0; m_wd = 0;
            if (others) m_own = p; else m_st = 0;
         end else begin
            done = s && a;
            bnd  = done && (c == 3'b000 || c == 3'b111);
            if (done && m_q < MH) m_q++;
            if (bnd && m_q >= MH && others) begin
               m_own = p; m_q = 0; m_wd = 0;
            end else if (s && !a) begin
               if (m_wd == TO - 1) begin m_st = 2; m_err = 1'b1; m_wd = 0; end
               else m_wd++;
            end else begin
               m_wd = 0;
            end
         end
      end else begin
         m_wd = 0;
         m_st = own_req ? 1 : 0;
      end
   endfunction

   task automatic check_model(input string nm);
      logic [N-1:0] eg;
      logic [1:0]   ei;
      eg = N'(1) << m_own;
      ei = 2'(m_own);
      n_cmp++;
      if (bus.gnt !== eg || bus.gnt_idx !== ei || bus.busy !== (m_st != 0) ||
          bus.bus_err !== m_err) begin
         n_bad++;
         $display("FAIL %s: gnt=%b idx=%0d busy=%b err=%b, want gnt=%b idx=%0d busy=%b err=%b",
                  nm, bus.gnt, bus.gnt_idx, bus.busy, bus.bus_err, eg, ei, m_st != 0, m_err);
      end
   endtask

   task automatic expect_out(input string nm, input logic [N-1:0] eg, input logic eb,
                             input logic ee);
      n_cmp++;
      if (bus.gnt !== eg || bus.busy !== eb || bus.bus_err !== ee) begin
         n_bad++;
         $display("FAIL %s: gnt=%b busy=%b err=%b, want gnt=%b busy=%b err=%b",
                  nm, bus.gnt, bus.busy, bus.bus_err, eg, eb, ee);
      end
   endtask

   task automatic step(input logic r_rst, input logic [N-1:0] r, input logic s,
                       input logic [2:0] c, input logic a, input string nm);
      @(negedge clk);
      rst       = r_rst;
      bus.req   = r;
      bus.i_stb = s;
      bus.i_cti = c;
      bus.i_ack = a;
      @(posedge clk);
      model_step(r_rst, r, s, c, a);
      #1;
      check_model(nm);
   endtask

   typedef struct {
      logic         rst;
      logic [N-1:0] req;
      logic [N-1:0] gnt;
      logic         busy;
   } vec_t;

   vec_t tbl[15];

   initial begin
      logic [N-1:0] rq;
      logic [2:0]   ctis[5];
      bus.req   = '0;
      bus.i_stb = 1'b0;
      bus.i_cti = 3'b000;
      bus.i_ack = 1'b0;

      // Basic grant, parking, alternation and wrap of the round-robin search.
      tbl[0]  = '{1'b1, 3'b000, 3'b001, 1'b0};
      tbl[1]  = '{1'b0, 3'b010, 3'b010, 1'b1};
      tbl[2]  = '{1'b0, 3'b000, 3'b010, 1'b0};
      tbl[3]  = '{1'b1, 3'b000, 3'b001, 1'b0};
      tbl[4]  = '{1'b0, 3'b011, 3'b010, 1'b1};
      tbl[5]  = '{1'b0, 3'b001, 3'b001, 1'b1};
      tbl[6]  = '{1'b0, 3'b011, 3'b001, 1'b1};
      tbl[7]  = '{1'b0, 3'b010, 3'b010, 1'b1};
      tbl[8]  = '{1'b0, 3'b110, 3'b010, 1'b1};
      tbl[9]  = '{1'b0, 3'b100, 3'b100, 1'b1};
      tbl[10] = '{1'b0, 3'b101, 3'b100, 1'b1};
      tbl[11] = '{1'b0, 3'b001, 3'b001, 1'b1};
      tbl[12] = '{1'b0, 3'b000, 3'b001, 1'b0};
      tbl[13] = '{1'b0, 3'b001, 3'b001, 1'b1};
      tbl[14] = '{1'b0, 3'b000, 3'b001, 1'b0};
      for (int i = 0; i < 15; i++) begin
         step(tbl[i].rst, tbl[i].req, 1'b0, 3'b000, 1'b0, $sformatf("vec%0d_model", i));
         expect_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].busy, 1'b0);
      end

      // Quantum preemption after the fourth classic ack.
      step(1'b1, 3'b000, 1'b0, 3'b000, 1'b0, "quant_rst");
      step(1'b0, 3'b001, 1'b0, 3'b000, 1'b0, "quant_own0");
      expect_out("quant_own0", 3'b001, 1'b1, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         step(1'b0, 3'b011, 1'b1, 3'b000, 1'b1, $sformatf("quant_ack%0d_model", k));
         expect_out($sformatf("quant_ack%0d", k), (k < 4) ? 3'b001 : 3'b010, 1'b1, 1'b0);
      end
      step(1'b0, 3'b011, 1'b0, 3'b000, 1'b0, "quant_hold");
      expect_out("quant_hold", 3'b010, 1'b1, 1'b0);

      // No rotation inside an 8-beat incrementing burst.
      step(1'b1, 3'b000, 1'b0, 3'b000, 1'b0, "burst_rst");
      step(1'b0, 3'b001, 1'b0, 3'b000, 1'b0, "burst_own0");
      for (int k = 1; k <= 8; k++) begin
         step(1'b0, 3'b011, 1'b1, (k < 8) ? 3'b010 : 3'b111, 1'b1,
              $sformatf("burst_beat%0d_model", k));
         expect_out($sformatf("burst_beat%0d", k), (k < 8) ? 3'b001 : 3'b010, 1'b1, 1'b0);
      end

      // Watchdog: error on the TO-th unacked cycle; none when the ack lands on that cycle.
      step(1'b1, 3'b000, 1'b0, 3'b000, 1'b0, "wd_rst");
      step(1'b0, 3'b001, 1'b0, 3'b000, 1'b0, "wd_own0");
      for (int k = 1; k <= TO; k++) begin
         step(1'b0, 3'b001, 1'b1, 3'b000, 1'b0, $sformatf("wd_stb%0d_model", k));
         expect_out($sformatf("wd_stb%0d", k), 3'b001, 1'b1, k == TO);
      end
      step(1'b0, 3'b001, 1'b0, 3'b000, 1'b0, "wd_after");
      expect_out("wd_after", 3'b001, 1'b1, 1'b0);
      for (int k = 1; k <= TO; k++) begin
         step(1'b0, 3'b001, 1'b1, 3'b000, k == TO, $sformatf("wd_late%0d_model", k));
         expect_out($sformatf("wd_late%0d", k), 3'b001, 1'b1, 1'b0);
      end
      step(1'b0, 3'b001, 1'b0, 3'b000, 1'b0, "wd_late_after");
      expect_out("wd_late_after", 3'b001, 1'b1, 1'b0);

      // Reset in the middle of a burst owned by master 1.
      step(1'b1, 3'b000, 1'b0, 3'b000, 1'b0, "mrst_rst");
      step(1'b0, 3'b010, 1'b0, 3'b000, 1'b0, "mrst_own1");
      for (int k = 0; k < 3; k++) step(1'b0, 3'b011, 1'b1, 3'b010, 1'b1, "mrst_beat");
      step(1'b1, 3'b011, 1'b1, 3'b010, 1'b1, "mrst_hit_model");
      expect_out("mrst_hit", 3'b001, 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b0, 3'b000, 1'b0, "mrst_after_model");
      expect_out("mrst_after", 3'b001, 1'b0, 1'b0);

      // Random traffic against the reference.
      ctis = '{3'b000, 3'b001, 3'b010, 3'b111, 3'b011};
      rq   = '0;
      for (int i = 0; i < 3000; i++) begin
         logic s, a, r;
         for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
         s = ($urandom_range(0, 3) != 0);
         a = ((i / 200) % 2 == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         r = ($urandom_range(0, 299) == 0);
         step(r, rq, s, ctis[$urandom_range(0, 4)], a, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
